// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings,
// FSM state encoding and the M-extension funct7 used by the main decoder.
package muldiv_ctrl_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage to multiply/divide sequencer handshake: operation request in,
// stall/done/result back.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, src_a, src_b,
    input  stall, done, result
  );

  modport slave (
    input  start, flush, funct3, src_a, src_b,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on
// the shared 2*XLEN accumulator ({hi, lo} = {product hi, multiplier} or {remainder, quotient}).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_nx
);

  logic [XLEN:0]   sum_s;
  logic [XLEN+1:0] diff_s;

  // Single-iteration datapath, selected by is_div
  always_comb begin
    sum_s  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    diff_s = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, operand};
    acc_nx = acc;
    if (is_div) begin
      // The shifted partial remainder needs XLEN+1 bits; a clear top bit of
      // the difference means the trial subtraction succeeded.
      if (!diff_s[XLEN+1]) begin
        acc_nx = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_nx = {sum_s, acc[XLEN-1:1]};
      end else begin
        acc_nx = {1'b0, acc[2*XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: holds the pipeline while a radix-2 multiply or restoring
// divide iterates XLEN cycles, then applies sign fix-up and emits a done pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_ctrl_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

  state_e            state_r, state_nx_s;
  logic              stall_s;
  logic              launch_s;

  logic [2:0]        op_r;
  logic              neg_res_r;
  logic              neg_rem_r;
  logic [XLEN-1:0]   opnd_r;
  logic [2*XLEN-1:0] acc_r;
  logic [CW-1:0]     cnt_r;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  logic              sgn_a_s, sgn_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              is_div_in_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [2*XLEN-1:0] acc_init_s;
  logic [XLEN-1:0]   opnd_init_s;
  logic              neg_res_init_s, neg_rem_init_s;

  logic [2*XLEN-1:0] acc_step_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s;
  logic [XLEN-1:0]   fix_sel_s;

  // Operand decode at launch: magnitudes, signs and the divide special cases
  always_comb begin
    sgn_a_s     = signed_a(bus.funct3) & bus.src_a[XLEN-1];
    sgn_b_s     = signed_b(bus.funct3) & bus.src_b[XLEN-1];
    mag_a_s     = sgn_a_s ? (~bus.src_a + ONE_X) : bus.src_a;
    mag_b_s     = sgn_b_s ? (~bus.src_b + ONE_X) : bus.src_b;
    is_div_in_s = bus.funct3[2];
    div_zero_s  = is_div_in_s & (bus.src_b == ZERO_X);
    ovf_s       = ((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM)) &
                  (bus.src_a == MIN_X) & (bus.src_b == ONES_X);
    special_s   = div_zero_s | ovf_s;
    opnd_init_s = is_div_in_s ? mag_b_s : mag_a_s;
    // Special cases preload the final {remainder, quotient} and disable fix-up
    if (div_zero_s) begin
      acc_init_s = {bus.src_a, ONES_X};
    end else if (ovf_s) begin
      acc_init_s = {ZERO_X, MIN_X};
    end else if (is_div_in_s) begin
      acc_init_s = {ZERO_X, mag_a_s};
    end else begin
      acc_init_s = {ZERO_X, mag_b_s};
    end
    if (special_s) begin
      neg_res_init_s = 1'b0;
      neg_rem_init_s = 1'b0;
    end else begin
      neg_res_init_s = sgn_a_s ^ sgn_b_s;
      neg_rem_init_s = sgn_a_s;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_r[2]),
    .acc     (acc_r),
    .operand (opnd_r),
    .acc_nx  (acc_step_s)
  );

  // Sign correction and result selection for the FIX state
  always_comb begin
    prod_fix_s = neg_res_r ? (~acc_r + {ZERO_X, ONE_X}) : acc_r;
    quo_fix_s  = neg_res_r ? (~acc_r[XLEN-1:0] + ONE_X) : acc_r[XLEN-1:0];
    rem_fix_s  = neg_rem_r ? (~acc_r[2*XLEN-1:XLEN] + ONE_X) : acc_r[2*XLEN-1:XLEN];
    case (op_r)
      MD_MUL:                       fix_sel_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_sel_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_sel_s = quo_fix_s;
      MD_REM, MD_REMU:              fix_sel_s = rem_fix_s;
      default:                      fix_sel_s = ZERO_X;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and stall; flush wins in every state
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    launch_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          launch_s   = 1'b1;
          stall_s    = 1'b1;
          state_nx_s = special_s ? S_FIX : S_CALC;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_CALC: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          state_nx_s = S_IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = S_FIX;
        end else begin
          state_nx_s = S_CALC;
        end
      end
      S_FIX: begin
        stall_s = 1'b1;
        if (bus.flush) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      // start is ignored here: it is still the instruction just completed
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration, result and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 3'b000;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      opnd_r    <= ZERO_X;
      acc_r     <= {2*XLEN{1'b0}};
      cnt_r     <= {CW{1'b0}};
      done_r    <= 1'b0;
      result_r  <= ZERO_X;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (launch_s) begin
            op_r      <= bus.funct3;
            neg_res_r <= neg_res_init_s;
            neg_rem_r <= neg_rem_init_s;
            opnd_r    <= opnd_init_s;
            acc_r     <= acc_init_s;
            cnt_r     <= CNT_LAST;
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            result_r <= fix_sel_s;
            done_r   <= 1'b1;
          end
        end
        S_DONE:  done_r <= 1'b0;
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign bus.stall  = stall_s;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the RV32M extension in the execute stage. It accepts one MUL/DIV-class operation from the ALU path, iterates a radix-2 shift-add multiplier or restoring divider over XLEN cycles, and holds the pipeline with a stall signal until the result is ready. It sits beside the ALU; the main decoder steers R-type instructions with funct7=0000001 here instead of to the ALU.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  EX stage holds a valid M-extension instruction
flush  in  1  synchronous abort, from a branch mispredict or trap
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  XLEN  rs1 operand (multiplicand/dividend)
src_b  in  XLEN  rs2 operand (multiplier/divisor)
stall  out  1  freeze IF/ID/EX; combinational
done  out  1  one-cycle result-valid pulse
result  out  XLEN  final result; valid only while done=1

Behaviour:
- FSM states: IDLE, CALC, FIX, DONE. Reset puts the FSM in IDLE. Reset values: done=0, result=0, iteration counter=0, all internal accumulators=0.
- IDLE: when start=1 and flush=0, latch funct3, the operand magnitudes and the sign flags.
  - Operands are signed for MULH/DIV/REM. For MULHSU, src_a is signed and src_b unsigned. All other operations are unsigned.
  - Next state is FIX for the special cases below, otherwise CALC with the counter loaded to XLEN-1.
- CALC: one iteration per cycle; the counter decrements. When the counter reaches 0, go to FIX. CALC lasts exactly XLEN cycles.
  - Multiply: 2*XLEN-bit product register; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: remainder/quotient shift register; trial subtract; the quotient bit is 1 when the difference is non-negative.
- FIX: apply sign correction (two's-complement negate when the signs differ; the remainder takes the dividend's sign). Select the output: the low half for MUL, the high half for MULH/MULHSU/MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU. Register the selection into result. Next state is DONE.
- DONE: done=1 and result is valid. start is ignored this cycle, because the same instruction is still presented. Next state is IDLE.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. stall is 0 in DONE, so EX advances at the end of the DONE cycle.
- Latency: for a start sampled at edge T, done is high in the cycle after edge T+XLEN+1 (XLEN+2 cycles total). Special cases take 2 cycles.
- Special cases skip CALC and go straight to FIX:
  - Divisor 0: quotient all ones; remainder = dividend (both signed and unsigned forms).
  - Signed overflow (src_a = 0x80000000, src_b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
  - A multiply with either operand 0 is not special-cased; it takes the full latency.
- flush: takes priority in every state. The next state is IDLE, done stays 0 and result is unchanged. A flush coincident with start in IDLE does not launch an operation.
- rst asserted mid-operation: the block returns immediately to IDLE with reset values. No partial result is emitted.
- Back-to-back: a new start is accepted earliest in the cycle after DONE. The result of the previous operation is not retained once done drops.

Decomposition:
- Shared package holds:
  - funct3 encoding constants: MD_MUL … MD_REMU.
  - FSM state encodings: 2-bit S_IDLE, S_CALC, S_FIX, S_DONE.
  - The M-extension funct7 constant, 7'b0000001, which the main decoder also uses.
- One natural sub-module, muldiv_step: the combinational single-iteration add/shift and subtract/shift datapath. It is instantiated once and selected by an is_div flag. The FSM, counter, sign handling and output registers stay in muldiv_ctrl.

Test Plan:
1. MUL src_a=7, src_b=6 → stall high for 34 cycles, done pulses on cycle 34, result=42. MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE.
2. Signed mix: MULH 0xFFFFFFFE(-2)×3 → result=0xFFFFFFFF. MULHSU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFF. DIV -7/2 → result=0xFFFFFFFD(-3). REM -7/2 → result=0xFFFFFFFF(-1).
3. DIVU 100/0 → result=0xFFFFFFFF. REMU 100/0 → result=100. DIV 0x80000000/0xFFFFFFFF → result=0x80000000. REM of the same operands → result=0. All four assert done 2 cycles after start.
4. DIV in progress: assert flush at CALC cycle 10 → stall falls the next cycle, done never asserts, and the FSM accepts a new start the following cycle.
5. Assert rst mid-CALC → stall=0, done=0, result=0 immediately. After release, DIVU 9/3 → result=3 with the full latency.
6. Hold start high through DONE, then hold it for a second instruction → exactly one done per instruction, and no spurious relaunch in the DONE cycle.
